// File: rtl/serial_adder_n_bit.sv
// ---------------------------------------------------------------------------
// serial_adder_n_bit
//
// Bit-serial WIDTH-bit adder built around a single 1-bit full adder. On an
// accepted Start the operands and carry-in are latched, then one bit per clock
// is added LSB-first. The carry is recirculated through a flip-flop and the
// sum bits are collected in a right-shifting result register. The visible
// result (Sum/CarryOut/Overflow) only updates when the last bit completes.
//
// Ports:
//   Clock     in   rising-edge clock
//   Reset     in   asynchronous active-high reset
//   Start     in   begin an addition (accepted in IDLE or DONE)
//   A, B      in   WIDTH-bit operands, sampled on the accepting edge
//   CarryIn   in   initial carry, sampled on the accepting edge
//   Busy      out  high while bits are being processed (ADD state)
//   Done      out  one-cycle pulse, result valid (DONE state)
//   Sum       out  registered WIDTH-bit result
//   CarryOut  out  carry out of the MSB
//   Overflow  out  signed overflow (carry into MSB XOR carry out of MSB)
//   DbgState  out  current FSM state: 0=IDLE, 1=ADD, 2=DONE
//
// Handshake: Start is a request sampled at every rising edge; it is accepted
// only when the FSM is in IDLE or DONE and is ignored while Busy is high.
// Done is a single-cycle pulse announcing that Sum/CarryOut/Overflow hold the
// result of the most recently accepted operation.
// ---------------------------------------------------------------------------

module full_adder_1_bit (
  input  logic A,
  input  logic B,
  input  logic CarryIn,
  output logic Sum,
  output logic CarryOut
);
  assign Sum      = A ^ B ^ CarryIn;
  assign CarryOut = (A & B) | (A & CarryIn) | (B & CarryIn);
endmodule

module serial_adder_n_bit #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Overflow,
  output logic [1:0]       DbgState
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum;
  logic fa_cout;
  logic accept;
  logic last_bit;

  full_adder_1_bit u_fa (
    .A        (a_q[0]),
    .B        (b_q[0]),
    .CarryIn  (carry_q),
    .Sum      (fa_sum),
    .CarryOut (fa_cout)
  );

  // A new operation may start from IDLE or straight out of DONE.
  assign accept   = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_bit = (state_q == S_ADD) && (cnt_q == LAST_BIT);

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_ADD;
      S_ADD:   if (cnt_q == LAST_BIT) state_d = S_DONE;
      S_DONE:  state_d = Start ? S_ADD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    Busy     = (state_q == S_ADD);
    Done     = (state_q == S_DONE);
    DbgState = state_q;
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = A;
      b_d     = B;
      carry_d = CarryIn;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == S_ADD) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = fa_cout;
      cnt_d   = cnt_q + CNT_W'(1);
      res_d   = {fa_sum, res_q[WIDTH-1:1]};
      if (last_bit) begin
        // On the MSB step carry_q is the carry into the MSB, so the signed
        // overflow falls out directly without a separate register.
        sum_d  = {fa_sum, res_q[WIDTH-1:1]};
        cout_d = fa_cout;
        ovf_d  = carry_q ^ fa_cout;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Sum      = sum_q;
  assign CarryOut = cout_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_n_bit.sv
module tb_serial_adder_n_bit;

  localparam int W  = 8;
  localparam int W4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle_no = 0;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  // ---------------- DUT (WIDTH=8) ----------------
  logic         Start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         CarryIn = 1'b0;
  logic         Busy, Done, CarryOut, Overflow;
  logic [W-1:0] Sum;
  logic [1:0]   DbgState;

  serial_adder_n_bit #(.WIDTH(W)) dut (
    .Clock(clk), .Reset(rst), .Start(Start), .A(A), .B(B), .CarryIn(CarryIn),
    .Busy(Busy), .Done(Done), .Sum(Sum), .CarryOut(CarryOut),
    .Overflow(Overflow), .DbgState(DbgState)
  );

  // ---------------- DUT (WIDTH=4) for exhaustive sweep ----------------
  logic          Start4 = 1'b0;
  logic [W4-1:0] A4 = '0, B4 = '0;
  logic          Cin4 = 1'b0;
  logic          Busy4, Done4, Cout4, Ovf4;
  logic [W4-1:0] Sum4;
  logic [1:0]    Dbg4;

  serial_adder_n_bit #(.WIDTH(W4)) dut4 (
    .Clock(clk), .Reset(rst), .Start(Start4), .A(A4), .B(B4), .CarryIn(Cin4),
    .Busy(Busy4), .Done(Done4), .Sum(Sum4), .CarryOut(Cout4),
    .Overflow(Ovf4), .DbgState(Dbg4)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];   // {ovf, cout, sum}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic, signed range check for overflow.
  task automatic model(input int a, input int b, input int cin, input int w,
                       output int sum, output int cout, output int ovf);
    int t, sa, sb, s;
    t    = a + b + cin;
    sum  = t % (1 << w);
    cout = t >> w;
    sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    s    = sa + sb + cin;
    ovf  = ((s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)))) ? 1 : 0;
  endtask

  // ---------------- driver: one operation on the 8-bit DUT ----------------
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] e_sum, input logic e_cout,
                        input logic e_ovf);
    logic [W+1:0] exp;
    logic [W-1:0] prev_sum;
    int busy_cnt, cyc;
    bit got, held;
    exp_q.push_back({e_ovf, e_cout, e_sum});
    @(negedge clk);
    prev_sum = Sum;
    A = a; B = b; CarryIn = cin; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    // scramble operands after the accepting edge; must have no effect
    A = W'($urandom); B = W'($urandom); CarryIn = 1'($urandom);
    busy_cnt = 0; cyc = 0; got = 0; held = 1;
    while (!got && cyc < 4 * W) begin
      if (Done) got = 1;
      else begin
        if (Busy) busy_cnt++;
        if (Sum !== prev_sum) held = 0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_busy_cycles"}, busy_cnt, W);
    check({name, "_sum_held"}, 32'(held), 32'd1);
    exp = exp_q.pop_front();
    check({name, "_sum"}, 32'(Sum), 32'(exp[W-1:0]));
    check({name, "_cout"}, 32'(CarryOut), 32'(exp[W]));
    check({name, "_ovf"}, 32'(Overflow), 32'(exp[W+1]));
    check({name, "_busy_at_done"}, 32'(Busy), 32'd0);
    @(posedge clk); #1;
    check({name, "_done_pulse"}, 32'(Done), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout, ovf;
  } vec_t;
  vec_t tbl[6];

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- main test ----------------
  initial begin
    int cyc, dones, es, ec, eo, prev_done, a4, b4, c4;
    logic [W-1:0] ra, rb;
    logic rc;

    tbl[0] = '{"t5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    tbl[1] = '{"tff_00", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{"t80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[3] = '{"t7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{"tff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{"t00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    // reset state (while in reset, then after release)
    #12;
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_sum", 32'(Sum), 0);
    check("rst_cout", 32'(CarryOut), 0);
    check("rst_ovf", 32'(Overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(Busy), 0);
    check("idle_state", 32'(DbgState), 0);

    // table-driven vectors
    for (int i = 0; i < 6; i++)
      run_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].ovf);

    // Start held high: operand changes during ADD ignored, capture at DONE edge
    @(negedge clk);
    A = 8'h01; B = 8'h02; CarryIn = 1'b0; Start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    A = 8'h10; B = 8'h20;
    cyc = 0;
    while (!Done && cyc < 4 * W) begin @(posedge clk); #1; cyc++; end
    check("held_first_done", 32'(Done), 1);
    check("held_first_sum", 32'(Sum), 32'h03);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!Done && cyc < 4 * W);
    Start = 1'b0;
    check("held_spacing", cyc, W + 1);
    check("held_second_sum", 32'(Sum), 32'h30);
    check("held_second_cout", 32'(CarryOut), 0);
    @(posedge clk); #1;
    check("held_back_idle_busy", 32'(Busy), 0);
    check("held_back_idle_done", 32'(Done), 0);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    A = 8'hAA; B = 8'h55; CarryIn = 1'b0; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(Busy), 0);
    check("abort_done", 32'(Done), 0);
    check("abort_sum", 32'(Sum), 0);
    check("abort_cout", 32'(CarryOut), 0);
    check("abort_ovf", 32'(Overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (Done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op("after_rst", 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0);

    // randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      model(int'(ra), int'(rb), int'(rc), W, es, ec, eo);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_op("rand", ra, rb, rc, W'(es), 1'(ec), 1'(eo));
    end

    // exhaustive sweep at WIDTH=4, back-to-back with Start held high
    @(negedge clk);
    A4 = '0; B4 = '0; Cin4 = 1'b0; Start4 = 1'b1;
    prev_done = 0;
    for (int idx = 0; idx < 512; idx++) begin
      c4 = idx & 1; a4 = (idx >> 1) & 15; b4 = (idx >> 5) & 15;
      @(posedge clk); #1;   // accepting edge
      cyc = 0;
      while (!Done4 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      model(a4, b4, c4, W4, es, ec, eo);
      check("sweep_done", 32'(Done4), 1);
      check("sweep_cout_sum", 32'({Cout4, Sum4}), 32'(ec * 16 + es));
      check("sweep_ovf", 32'(Ovf4), 32'(eo));
      if (idx > 0) check("sweep_spacing", cycle_no - prev_done, W4 + 1);
      prev_done = cycle_no;
      if (idx < 511) begin
        A4 = W4'(((idx + 1) >> 1) & 15);
        B4 = W4'(((idx + 1) >> 5) & 15);
        Cin4 = 1'((idx + 1) & 1);
      end else begin
        Start4 = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("sweep_end_idle", 32'(Busy4), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
